// File: rtl/bus_pkg.sv
// Shared types, address-map constants and the region decode function.
package bus_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned FC_W   = 3;
    localparam int unsigned CNT_W  = 7;
    localparam int unsigned BOOT_W = 3;
    localparam int unsigned EN_W   = 4;

    typedef enum logic [1:0] {
        REG_UNMAP = 2'd0,
        REG_RAM   = 2'd1,
        REG_IO    = 2'd2,
        REG_ROM   = 2'd3
    } region_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2,
        ERR    = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] RAM_LO   = 4'd1;
    localparam logic [ADDR_W-1:0] RAM_HI   = 4'd7;
    localparam logic [ADDR_W-1:0] IO_PAGE  = 4'd14;
    localparam logic [ADDR_W-1:0] ROM_PAGE = 4'd15;

    // Region for a bus cycle; the boot overlay overrides address and privilege.
    function automatic region_t decode(input logic [ADDR_W-1:0] addr_hi,
                                       input logic              supervisor,
                                       input logic              boot);
        region_t r;
        r = REG_UNMAP;
        if (boot)
            r = REG_ROM;
        else if (addr_hi >= RAM_LO && addr_hi <= RAM_HI)
            r = REG_RAM;
        else if (addr_hi == IO_PAGE && supervisor)
            r = REG_IO;
        else if (addr_hi == ROM_PAGE && supervisor)
            r = REG_ROM;
        return r;
    endfunction

    // One-hot enable vector, bit index equals the region encoding.
    function automatic logic [EN_W-1:0] region_onehot(input region_t r);
        return EN_W'(4'd1 << r);
    endfunction

endpackage

// File: rtl/bus_ctrl_if.sv
// CPU-side bus signals and region enables of the bus-cycle controller.
interface bus_ctrl_if;

    logic                      as_n;
    logic [bus_pkg::ADDR_W-1:0] addr_hi;
    logic [bus_pkg::FC_W-1:0]   fc;
    logic                      dtack_bus;
    logic                      rom_en;
    logic                      ram_en;
    logic                      io_en;
    logic                      unmap_en;
    logic                      berr_to;
    logic                      busy;

    modport master (
        output as_n, addr_hi, fc, dtack_bus,
        input  rom_en, ram_en, io_en, unmap_en, berr_to, busy
    );

    modport slave (
        input  as_n, addr_hi, fc, dtack_bus,
        output rom_en, ram_en, io_en, unmap_en, berr_to, busy
    );

endinterface

// File: rtl/sync2.sv
// Generic two-flop synchronizer with asynchronous reset to a chosen value.
module sync2 #(
    parameter int unsigned WIDTH   = 1,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= {WIDTH{RST_VAL}};
            q    <= {WIDTH{RST_VAL}};
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bus_ctrl.sv
// 68000 bus-cycle tracker: region select, watchdog bus error and boot overlay.
module bus_ctrl
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned BOOT_CYCLES    = 4
) (
    input  logic       clk,
    input  logic       reset,
    bus_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BOOT_W-1:0] BOOT_INIT = BOOT_W'(BOOT_CYCLES);

    logic              as_s;
    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [BOOT_W-1:0] boot_left;
    logic [EN_W-1:0]   en;
    logic              berr;
    logic              busy;
    region_t           region_c;

    sync2 #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_as_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.as_n),
        .q     (as_s)
    );

    // Region for the cycle about to start, sampled only on IDLE->ACTIVE.
    assign region_c = decode(bus.addr_hi, bus.fc[2], boot_left != '0);

    // Cycle FSM with registered enables, bus error and busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            boot_left <= BOOT_INIT;
            en        <= '0;
            berr      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!as_s) begin
                        state <= ACTIVE;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        en    <= region_onehot(region_c);
                        if (boot_left != '0)
                            boot_left <= boot_left - BOOT_W'(1);
                    end
                end
                ACTIVE: begin
                    if (as_s) begin
                        // CPU abandoned the cycle before any acknowledge.
                        state <= IDLE;
                        busy  <= 1'b0;
                        en    <= '0;
                        berr  <= 1'b0;
                    end else if (!bus.dtack_bus) begin
                        // Acknowledge wins over a watchdog expiring this edge.
                        state <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        state <= ERR;
                        berr  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE, ERR: begin
                    if (as_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        en    <= '0;
                        berr  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    en    <= '0;
                    berr  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.unmap_en = en[REG_UNMAP];
    assign bus.ram_en   = en[REG_RAM];
    assign bus.io_en    = en[REG_IO];
    assign bus.rom_en   = en[REG_ROM];
    assign bus.berr_to  = berr;
    assign bus.busy     = busy;

endmodule

// File: tb/tb_bus_ctrl.sv
// Directed bench for bus_ctrl: boot overlay, decode, latency, watchdog, race, reset.
module tb_bus_ctrl;

    localparam logic [3:0] EN_NONE  = 4'b0000;
    localparam logic [3:0] EN_ROM   = 4'b1000;
    localparam logic [3:0] EN_RAM   = 4'b0100;
    localparam logic [3:0] EN_IO    = 4'b0010;
    localparam logic [3:0] EN_UNMAP = 4'b0001;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    bus_ctrl_if bus ();

    bus_ctrl #(
        .TIMEOUT_CYCLES (8),
        .BOOT_CYCLES    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [3:0] en_vec;
    assign en_vec = {bus.rom_en, bus.ram_en, bus.io_en, bus.unmap_en};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a new cycle and check the enable two edges after as_n is sampled.
    task automatic start_cycle(input string tag, input logic [3:0] a,
                               input logic [2:0] f, input logic [3:0] exp);
        bus.addr_hi = a;
        bus.fc      = f;
        bus.as_n    = 1'b0;
        tick();
        tick();
        tick();
        check({tag, "_en"}, 32'(en_vec), 32'(exp));
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    endtask

    task automatic ack();
        bus.dtack_bus = 1'b0;
        tick();
        bus.dtack_bus = 1'b1;
    endtask

    task automatic end_cycle(input string tag);
        bus.dtack_bus = 1'b1;
        bus.as_n      = 1'b1;
        tick();
        tick();
        tick();
        check({tag, "_clr"}, 32'({en_vec, bus.berr_to, bus.busy}), 32'd0);
    endtask

    task automatic full_cycle(input string tag, input logic [3:0] a,
                              input logic [2:0] f, input logic [3:0] exp);
        start_cycle(tag, a, f, exp);
        ack();
        end_cycle(tag);
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset         = 1'b1;
        bus.as_n      = 1'b1;
        bus.dtack_bus = 1'b1;
        bus.addr_hi   = 4'h0;
        bus.fc        = 3'd0;
        #1;
        check("reset_outs", 32'({en_vec, bus.berr_to, bus.busy}), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("post_reset_outs", 32'({en_vec, bus.berr_to, bus.busy}), 32'd0);

        // Boot overlay: four forced ROM cycles, then normal decode.
        full_cycle("boot1", 4'h0, 3'd6, EN_ROM);
        full_cycle("boot2", 4'h0, 3'd6, EN_ROM);
        full_cycle("boot3", 4'h0, 3'd6, EN_ROM);
        full_cycle("boot4", 4'h0, 3'd6, EN_ROM);
        full_cycle("boot5", 4'h0, 3'd6, EN_UNMAP);

        // Decode and supervisor protection.
        full_cycle("dec_ram", 4'h3, 3'd5, EN_RAM);
        full_cycle("dec_io_sup", 4'hE, 3'd6, EN_IO);
        full_cycle("dec_io_usr", 4'hE, 3'd2, EN_UNMAP);
        full_cycle("dec_rom_usr", 4'hF, 3'd1, EN_UNMAP);
        full_cycle("dec_hole", 4'hA, 3'd6, EN_UNMAP);
        full_cycle("dec_ram_hi", 4'h7, 3'd0, EN_RAM);
        full_cycle("dec_hole_lo", 4'h8, 3'd6, EN_UNMAP);

        // Latency and acknowledge.
        bus.addr_hi = 4'h3;
        bus.fc      = 3'd5;
        bus.as_n    = 1'b0;
        tick();
        tick();
        check("lat_e1", 32'(en_vec), 32'(EN_NONE));
        tick();
        check("lat_e2", 32'(en_vec), 32'(EN_RAM));
        for (int i = 0; i < 3; i++) tick();
        ack();
        check("ack_hold", 32'(en_vec), 32'(EN_RAM));
        for (int i = 0; i < 10; i++) tick();
        check("ack_done_berr", 32'(bus.berr_to), 32'd0);
        check("ack_done_en", 32'(en_vec), 32'(EN_RAM));
        bus.as_n = 1'b1;
        tick();
        tick();
        check("deassert_e1", 32'(en_vec), 32'(EN_RAM));
        tick();
        check("deassert_e2", 32'({en_vec, bus.berr_to, bus.busy}), 32'd0);

        // Watchdog timeout with dtack held high.
        start_cycle("to", 4'hF, 3'd6, EN_ROM);
        for (int i = 1; i < 8; i++) begin
            tick();
            check($sformatf("to_pre%0d", i), 32'(bus.berr_to), 32'd0);
        end
        tick();
        check("to_edge8", 32'(bus.berr_to), 32'd1);
        tick();
        tick();
        tick();
        check("to_hold_berr", 32'(bus.berr_to), 32'd1);
        check("to_hold_en", 32'(en_vec), 32'(EN_ROM));
        bus.as_n = 1'b1;
        tick();
        tick();
        check("to_rel_e1", 32'(bus.berr_to), 32'd1);
        tick();
        check("to_rel_e2", 32'({en_vec, bus.berr_to, bus.busy}), 32'd0);

        // Acknowledge arriving on the last watchdog count.
        start_cycle("race", 4'h1, 3'd5, EN_RAM);
        for (int i = 0; i < 7; i++) tick();
        ack();
        check("race_berr", 32'(bus.berr_to), 32'd0);
        for (int i = 0; i < 10; i++) tick();
        check("race_done_berr", 32'(bus.berr_to), 32'd0);
        check("race_done_busy", 32'(bus.busy), 32'd1);
        end_cycle("race");

        // Reset in ACTIVE restarts the boot overlay.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        full_cycle("rb1", 4'h0, 3'd6, EN_ROM);
        full_cycle("rb2", 4'h0, 3'd6, EN_ROM);
        full_cycle("rb3", 4'h0, 3'd6, EN_ROM);
        start_cycle("rb4", 4'h0, 3'd6, EN_ROM);
        reset = 1'b1;
        #1;
        check("rst_mid_outs", 32'({en_vec, bus.berr_to, bus.busy}), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("rst_rel_e1", 32'(en_vec), 32'(EN_NONE));
        tick();
        check("rst_rel_rom", 32'(en_vec), 32'(EN_ROM));
        ack();
        end_cycle("rst_rel");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
